// File: rtl/keypad_mem_ctrl.sv
// keypad_mem_ctrl: turns keypad key sequences into single write/read
// cycles on a 16x4 memory and holds the last accessed address/data.
// Ports: clock, reset (async, active-high); dav, key_data from the
// keypad encoder; mem_addr/mem_wdata/mem_we/mem_re/mem_rdata memory port;
// disp_addr/disp_data for the display; busy, error, state_dbg status.
module keypad_mem_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int RD_LATENCY     = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dav,
  input  logic [3:0] key_data,
  input  logic [3:0] mem_rdata,
  output logic [3:0] mem_addr,
  output logic [3:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  output logic [3:0] disp_addr,
  output logic [3:0] disp_data,
  output logic       busy,
  output logic       error,
  output logic [2:0] state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RD_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    WRITE  = 3'd3,
    R_ADDR = 3'd4,
    READ   = 3'd5,
    R_WAIT = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0]      dav_sync_q, dav_sync_d;
  logic [SYNC_STAGES-1:0][3:0] key_sync_q, key_sync_d;
  logic                        dav_prev_q, dav_prev_d;

  logic [3:0]    addr_q, addr_d;
  logic [3:0]    mem_addr_q, mem_addr_d;
  logic [3:0]    mem_wdata_q, mem_wdata_d;
  logic [3:0]    disp_addr_q, disp_addr_d;
  logic [3:0]    disp_data_q, disp_data_d;
  logic          error_q, error_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    wait_q, wait_d;

  logic       dav_s;
  logic [3:0] key;
  logic       key_evt;
  logic       is_digit;
  logic       waiting;
  logic       tmo_hit;

  // key_data runs through its own chain so it lines up with dav
  assign dav_s    = dav_sync_q[SYNC_STAGES-1];
  assign key      = key_sync_q[SYNC_STAGES-1];
  assign key_evt  = dav_s & ~dav_prev_q;
  assign is_digit = (key <= 4'd9);
  assign waiting  = state_q inside {W_ADDR, W_DATA, R_ADDR};
  // a key arriving on the expiry cycle takes precedence
  assign tmo_hit  = waiting && !key_evt && (tmo_q == TMO_LAST);

  always_comb begin
    dav_sync_d = {dav_sync_q[SYNC_STAGES-2:0], dav};
    key_sync_d = {key_sync_q[SYNC_STAGES-2:0], key_data};
    dav_prev_d = dav_s;
    tmo_d      = (waiting && !key_evt) ? tmo_q + 1'b1 : '0;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    disp_addr_d = disp_addr_q;
    disp_data_d = disp_data_q;
    error_d     = error_q;
    wait_d      = wait_q;
    unique case (state_q)
      IDLE: begin
        if (key_evt) begin
          unique case (1'b1)
            (key == KEY_HASH): begin
              state_d = W_ADDR;
              error_d = 1'b0;
            end
            (key == KEY_STAR): begin
              state_d = R_ADDR;
              error_d = 1'b0;
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      W_ADDR: begin
        if (key_evt) begin
          if (is_digit) begin
            addr_d  = key;
            state_d = W_DATA;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      W_DATA: begin
        if (key_evt) begin
          unique case (1'b1)
            is_digit: begin
              // load port and display on entry so WRITE shows them
              mem_addr_d  = addr_q;
              mem_wdata_d = key;
              disp_addr_d = addr_q;
              disp_data_d = key;
              state_d     = WRITE;
            end
            (key == KEY_STAR): state_d = IDLE;
            default: begin
              error_d = 1'b1;
              state_d = IDLE;
            end
          endcase
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: state_d = IDLE;
      R_ADDR: begin
        if (key_evt) begin
          if (is_digit) begin
            addr_d     = key;
            mem_addr_d = key;
            state_d    = READ;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      READ: begin
        wait_d  = 2'd0;
        state_d = R_WAIT;
      end
      R_WAIT: begin
        if (wait_q == RD_LAST) begin
          disp_data_d = mem_rdata;
          disp_addr_d = addr_q;
          state_d     = IDLE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dav_sync_q  <= '0;
      key_sync_q  <= '0;
      dav_prev_q  <= 1'b0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      disp_addr_q <= '0;
      disp_data_q <= '0;
      error_q     <= 1'b0;
      tmo_q       <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      dav_sync_q  <= dav_sync_d;
      key_sync_q  <= key_sync_d;
      dav_prev_q  <= dav_prev_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      disp_addr_q <= disp_addr_d;
      disp_data_q <= disp_data_d;
      error_q     <= error_d;
      tmo_q       <= tmo_d;
      wait_q      <= wait_d;
    end
  end

  // strobes decode the state register, so reset drops them at once
  assign mem_we    = (state_q == WRITE);
  assign mem_re    = (state_q == READ);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign disp_addr = disp_addr_q;
  assign disp_data = disp_data_q;
  assign busy      = (state_q != IDLE);
  assign error     = error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_mem_ctrl.sv
// tb_keypad_mem_ctrl: directed and random key sequences checked
// against a per-key command model with its own memory image.
module tb_keypad_mem_ctrl;

  localparam int SYNC = 2;
  localparam int TMO  = 100;
  localparam int RDL  = 1;

  localparam int S_IDLE = 0;
  localparam int S_WA   = 1;
  localparam int S_WD   = 2;
  localparam int S_RA   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dav = 1'b0;
  logic [3:0] key_data = 4'd0;
  logic [3:0] mem_rdata;
  logic [3:0] mem_addr;
  logic [3:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [3:0] disp_addr;
  logic [3:0] disp_data;
  logic       busy;
  logic       error;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  keypad_mem_ctrl #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO),
    .RD_LATENCY    (RDL)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .dav      (dav),
    .key_data (key_data),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .disp_addr(disp_addr),
    .disp_data(disp_data),
    .busy     (busy),
    .error    (error),
    .state_dbg(state_dbg)
  );

  logic [3:0] tbmem [16];
  logic [3:0] rpipe [2];
  logic       mem_init = 1'b0;

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) tbmem[i] <= 4'(i * 3 + 1);
      mem_init <= 1'b1;
    end else if (mem_we) begin
      tbmem[mem_addr] <= mem_wdata;
    end
    rpipe[0] <= tbmem[mem_addr];
    rpipe[1] <= rpipe[0];
  end
  assign mem_rdata = rpipe[RDL-1];

  int         we_seen = 0;
  int         re_seen = 0;
  logic [3:0] wa_seen = 4'd0;
  logic [3:0] wd_seen = 4'd0;
  logic [3:0] ra_seen = 4'd0;

  always @(negedge clock) begin
    if (!reset) begin
      if (mem_we) begin
        we_seen++;
        wa_seen = mem_addr;
        wd_seen = mem_wdata;
      end
      if (mem_re) begin
        re_seen++;
        ra_seen = mem_addr;
      end
    end
  end

  int         n_chk = 0;
  int         n_err = 0;
  int         m_state = S_IDLE;
  logic       m_err = 1'b0;
  logic [3:0] m_addr = 4'd0;
  logic [3:0] m_da = 4'd0;
  logic [3:0] m_dd = 4'd0;
  logic [3:0] m_wa = 4'd0;
  logic [3:0] m_wd = 4'd0;
  logic [3:0] m_ra = 4'd0;
  int         m_we = 0;
  int         m_re = 0;
  logic [3:0] ref_mem [16];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_key(input logic [3:0] k);
    logic dig;
    dig = (k <= 4'd9);
    case (m_state)
      S_IDLE: begin
        if (k == 4'hB) begin
          m_state = S_WA;
          m_err   = 1'b0;
        end else if (k == 4'hA) begin
          m_state = S_RA;
          m_err   = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      S_WA: begin
        if (dig) begin
          m_addr  = k;
          m_state = S_WD;
        end else begin
          m_err   = 1'b1;
          m_state = S_IDLE;
        end
      end
      S_WD: begin
        if (dig) begin
          ref_mem[m_addr] = k;
          m_we++;
          m_wa = m_addr;
          m_wd = k;
          m_da = m_addr;
          m_dd = k;
        end else if (k != 4'hA) begin
          m_err = 1'b1;
        end
        m_state = S_IDLE;
      end
      S_RA: begin
        if (dig) begin
          m_re++;
          m_ra = k;
          m_da = k;
          m_dd = ref_mem[k];
        end else begin
          m_err = 1'b1;
        end
        m_state = S_IDLE;
      end
      default: m_state = S_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("state", 32'(state_dbg), m_state);
    chk("error", 32'(error), 32'(m_err));
    chk("busy", 32'(busy), 32'(m_state != S_IDLE));
    chk("disp_addr", 32'(disp_addr), 32'(m_da));
    chk("disp_data", 32'(disp_data), 32'(m_dd));
    chk("we_cnt", we_seen, m_we);
    chk("re_cnt", re_seen, m_re);
    chk("wr_addr", 32'(wa_seen), 32'(m_wa));
    chk("wr_data", 32'(wd_seen), 32'(m_wd));
    chk("rd_addr", 32'(ra_seen), 32'(m_ra));
  endtask

  // any wait state left for 150+ cycles without a key has timed out
  task automatic press(input logic [3:0] k, input int hi, input int lo);
    @(negedge clock);
    dav      = 1'b1;
    key_data = k;
    repeat (hi) @(negedge clock);
    dav = 1'b0;
    repeat (lo) @(negedge clock);
    model_key(k);
    if (m_state != S_IDLE && hi + lo >= 150) begin
      m_err   = 1'b1;
      m_state = S_IDLE;
    end
    check_all();
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_err   = 1'b0;
    m_da    = 4'd0;
    m_dd    = 4'd0;
  endtask

  initial begin
    int n;
    int r;
    logic [3:0] k;
    for (int i = 0; i < 16; i++) ref_mem[i] = 4'(i * 3 + 1);

    repeat (3) @(negedge clock);
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_re", 32'(mem_re), 0);
    chk("rst_maddr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_disp", 32'({disp_addr, disp_data}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    press(4'hB, 3, 10);
    press(4'd3, 3, 10);
    press(4'd7, 3, 10);

    press(4'hB, 4, 10);
    press(4'd3, 4, 10);
    press(4'd5, 4, 10);
    press(4'hA, 2, 12);
    press(4'd3, 2, 12);

    press(4'd4, 3, 10);
    press(4'hB, 3, 10);
    press(4'hB, 3, 10);
    press(4'hA, 3, 10);
    press(4'd9, 3, 10);

    @(negedge clock);
    dav      = 1'b1;
    key_data = 4'hB;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("tmo_start", 32'(busy), 1);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("tmo_len", n, TMO);
    dav = 1'b0;
    repeat (10) @(negedge clock);
    model_key(4'hB);
    m_err   = 1'b1;
    m_state = S_IDLE;
    check_all();

    press(4'hB, 3, 10);
    press(4'd2, 3, 10);
    press(4'hA, 3, 10);

    press(4'hB, 10000, 10);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) k = 4'hB;
      else if (r < 40) k = 4'hA;
      else if (r < 44) k = 4'($urandom_range(12, 15));
      else k = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0)
        press(k, int'($urandom_range(2, 20)), int'($urandom_range(200, 260)));
      else
        press(k, int'($urandom_range(2, 20)), int'($urandom_range(8, 30)));
    end

    press(4'hB, 3, 10);
    press(4'd6, 3, 10);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", 32'(state_dbg), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_we", 32'(mem_we), 0);
    chk("arst_disp", 32'({disp_addr, disp_data}), 0);
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_all();
    press(4'hA, 3, 10);
    press(4'd6, 3, 10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_mem_ctrl.md
Name: keypad_mem_ctrl

Overview:
- Sequencing controller between the keypad encoder (dav, KeypadData) and a 16x4 data memory.
- Turns keypad key sequences into single write or read cycles on the memory port and holds the last accessed address/data for the 7-segment display logic.
- Runs entirely in the 50 MHz clock domain. dav arrives from the 20 Hz keypad domain and is synchronized and edge-detected internally.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on dav; legal values 2..3.
- TIMEOUT_CYCLES, 250000000: clock cycles allowed between keys of one command (5 s at 50 MHz); counter width is $clog2(TIMEOUT_CYCLES+1).
- RD_LATENCY, 1: memory read latency in cycles; legal values 1..2.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- dav  in  1  key-valid level from the keypad encoder; asynchronous to clock.
- key_data  in  4  key code: 0-9 digits, 4'hA = '*', 4'hB = '#'. Stable while dav is high.
- mem_rdata  in  4  memory read data.
- mem_addr  out  4  memory address.
- mem_wdata  out  4  memory write data.
- mem_we  out  1  write strobe, one cycle wide.
- mem_re  out  1  read strobe, one cycle wide.
- disp_addr  out  4  last accessed address.
- disp_data  out  4  last written or read data.
- busy  out  1  high in any state other than IDLE.
- error  out  1  sticky; set on an illegal key or a timeout; cleared by the next accepted '#' or '*'.
- state_dbg  out  3  current state encoding, for LEDs.

Behaviour:
- Reset (async): state = IDLE; all outputs 0; synchronizer, edge register and timeout counter cleared.
- Key event:
  - key_evt is a one-cycle pulse on the rising edge of the synchronized dav.
  - key_data is sampled in the same cycle as key_evt, using its own SYNC_STAGES-deep register chain so it stays aligned with dav.
  - Only key_evt advances the FSM.
- States and encodings:
  - IDLE=0
  - W_ADDR=1
  - W_DATA=2
  - WRITE=3
  - R_ADDR=4
  - READ=5
  - R_WAIT=6
- IDLE:
  - '#' goes to W_ADDR and clears error.
  - '*' goes to R_ADDR and clears error.
  - A digit sets error and stays in IDLE.
- W_ADDR:
  - A digit is latched into addr_reg; go to W_DATA.
  - '#' or '*' sets error; go to IDLE.
- W_DATA:
  - A digit is latched into data_reg; go to WRITE.
  - '*' aborts to IDLE without setting error.
  - '#' sets error; go to IDLE.
- WRITE, one cycle:
  - mem_we=1, mem_addr=addr_reg, mem_wdata=data_reg.
  - disp_addr and disp_data update in the same cycle.
  - Next state is IDLE.
- R_ADDR:
  - A digit is latched into addr_reg; go to READ.
  - '#' or '*' sets error; go to IDLE.
- READ, one cycle: mem_re=1, mem_addr=addr_reg; go to R_WAIT.
- R_WAIT:
  - Hold mem_addr for RD_LATENCY cycles.
  - On the last cycle, latch mem_rdata into disp_data and addr_reg into disp_addr.
  - Next state is IDLE.
- Timeout:
  - The counter runs only in W_ADDR, W_DATA and R_ADDR, and reloads to 0 on entry to each of these states and on every key_evt.
  - Reaching TIMEOUT_CYCLES-1 sets error and goes to IDLE.
  - If a key_evt lands in the same cycle the timeout expires, the key wins.
- Keys during WRITE, READ or R_WAIT are ignored and dropped; no error.
- mem_addr holds its last value in IDLE.
- mem_wdata changes only in WRITE.
- Addresses are limited to 0-9 by the keypad; addresses 10-15 are unreachable by design.
- Reset asserted mid-command:
  - Returns to IDLE immediately.
  - A strobe in progress is deasserted asynchronously.
  - disp_* are cleared.
- Holding dav high produces exactly one key_evt; the next event needs dav low for at least one synchronized sample.

Test Plan:
- Write: reset, then keys '#','3','7' → exactly one cycle with mem_we=1, mem_addr=3, mem_wdata=7; disp_addr=3, disp_data=7; busy returns to 0 in the next cycle; error=0.
- Read: memory model holds 5 at addr 3; keys '*','3' → mem_re pulse with mem_addr=3; after RD_LATENCY cycles disp_data=5, disp_addr=3.
- Illegal sequences:
  - Digit '4' in IDLE → error=1, no strobe.
  - Then '#','#' → error cleared by the first '#', set again by the second, state back to IDLE.
  - Then '*' → error=0.
- Timeout, with TIMEOUT_CYCLES=100: '#' then no key → after 100 cycles state=IDLE, error=1, mem_we never asserted.
- Abort and edge detection:
  - '#','2','*' → no write; error=0.
  - dav held high for 10k cycles → exactly one key_evt.
- Async reset asserted in W_DATA, between clock edges → state_dbg=0 and busy=0 with no clock edge; mem_we stays 0.
